scf_stream: RTL and testbench
=============================

# scf_stream

Streaming, parametrised successor to the combinational SCF control-flow filter. It accepts {tag, instruction} words over a valid/ready handshake and classifies each MIPS instruction as control-flow (CF) or not. It applies a run-time selectable policy to CF instructions whose tag is zero, and buffers results in a DEPTH-entry output FIFO. It sits between instruction fetch and decode in the Garuda pipeline.

## Interface
- TAG_W, 32: width of the tag/data word paired with each instruction.
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept; in_ready = !rst && state==RUN && count<DEPTH.
- in_instr  in  32  instruction.
- in_tag  in  TAG_W  tag; zero means "unauthorised".
- policy  in  2  0 PASS, 1 ZERO, 2 DROP, 3 HALT; sampled per word at acceptance.
- clr  in  1  one-cycle pulse; leaves HALT.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  FIFO head instruction.
- out_tag  out  TAG_W  FIFO head tag.
- out_viol  out  1  head word was a violation.
- halted  out  1  state==HALT.
- cf_cnt  out  CNT_W  CF instructions accepted.
- viol_cnt  out  CNT_W  violations accepted.

## Operation
- CF classification (op = instr[31:26]):
  - op 0 with funct (instr[5:0]) 8 or 9;
  - op 1 with rt (instr[20:16]) in {0,1,16,17};
  - op 2..7.
  - All other encodings, including 0x00000000, are non-CF.
- Violation = CF && in_tag==0. Non-CF words and non-violating CF words are always written unchanged, out_viol=0.
- Violation handling by policy:
  - PASS: written unchanged, out_viol=1.
  - ZERO: written as instr=0, tag=0, out_viol=1 (legacy SCF behaviour).
  - DROP: not written.
  - HALT: not written; state RUN→HALT on the accepting edge.
- State machine: RUN, HALT.
  - HALT→RUN on a clr edge.
  - clr in RUN is ignored.
  - In HALT, the FIFO keeps draining.
- Counters increment on accepted words (cf_cnt on CF, viol_cnt on violation) and saturate at all-ones. clr does not clear them.

## Timing
- Acceptance: in_valid && in_ready at a rising edge. FIFO write occurs on the same edge, so out_valid rises the next cycle when the FIFO was empty (latency 1).
- Pop: out_valid && out_ready at an edge.
- Push and pop in the same cycle are legal whenever count<DEPTH; count is unchanged.
- Full (count==DEPTH): in_ready=0 even if a pop is pending. No combinational ready path from out_ready.
- Empty: out_valid=0; out_instr/out_tag/out_viol hold their last value (don't-care).
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Reset (any time, including mid-stream): FIFO emptied, state RUN, counters 0, out_valid=0, out_instr=0, out_tag=0, out_viol=0, halted=0, in_ready=0 while rst is high.
- clr in the same cycle as a HALT-policy violation: violation wins, and the state ends in HALT.

## Configuration
- SCF_STREAM_STATS_EN:
  - defined: cf_cnt/viol_cnt counters are implemented as above;
  - undefined: no counter registers; cf_cnt and viol_cnt are tied to 0. Ports remain present in both cases.

## Structure
- Package scf_pkg:
  - opcode/funct/rt constants (OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ..OP_BGTZ, FN_JR, FN_JALR);
  - policy enum (POL_PASS, POL_ZERO, POL_DROP, POL_HALT);
  - state enum;
  - pure function is_cf(instr).
- Sub-module scf_fifo: parametrised synchronous FIFO (width 32+TAG_W+1, DEPTH), exposing full/empty/count. scf_stream holds classification, policy, FSM and counters.

## Test plan
- Non-CF passthrough: policy ZERO; push 0x00000820 tag 0 → out 0x00000820, out_viol=0, cf_cnt=0, 1-cycle latency.
- ZERO policy: push 0x10000000 tag 0 → out instr 0, out_viol=1; push 0x10000001 tag 1 → out unchanged, cf_cnt=2, viol_cnt=1.
- DROP policy: push 0x04110000 tag 0, then 0x20210001 tag 0 → only 0x20210001 emitted.
- HALT policy: push 0x00000008 tag 0 → halted=1, in_ready=0, earlier FIFO words still drain; clr pulse → halted=0, in_ready=1.
- Backpressure: out_ready=0, push 5 words with DEPTH=4 → in_ready drops after 4; release → order preserved, wrap-around correct.
- Reset mid-stream with 3 words buffered → out_valid=0 next cycle, counters 0 (with SCF_STREAM_STATS_EN), state RUN.

Source files
------------

// File: rtl/scf_pkg.sv
// Shared definitions for the streaming SCF control-flow filter:
// MIPS opcode/funct/rt encodings, policy and state enums, CF classifier.
package scf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;
  localparam logic [4:0] RT_BLTZAL  = 5'd16;
  localparam logic [4:0] RT_BGEZAL  = 5'd17;

  typedef enum logic [1:0] {
    POL_PASS = 2'd0,
    POL_ZERO = 2'd1,
    POL_DROP = 2'd2,
    POL_HALT = 2'd3
  } pol_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // True for jumps and branches; everything else (including nop) is non-CF.
  function automatic logic is_cf(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       res;
    op  = instr[31:26];
    fn  = instr[5:0];
    rt  = instr[20:16];
    res = 1'b0;
    case (op)
      OP_SPECIAL: res = (fn == FN_JR) || (fn == FN_JALR);
      OP_REGIMM:  res = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                        (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: res = 1'b1;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/scf_fifo.sv
// Synchronous FIFO, DEPTH a power of two. Head word is read straight from
// storage, so it holds its last value while empty.
module scf_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers (natural wrap) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/scf_stream.sv
// Streaming SCF control-flow filter: classifies MIPS words, applies the
// unauthorised-CF policy and buffers results in scf_fifo.
// Optional feature macro: SCF_STREAM_STATS_EN (statistics counters).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | accepting words while the FIFO has room
// ST_HALT | HALT-policy violation seen; input blocked, FIFO drains, clr resumes
module scf_stream
  import scf_pkg::*;
#(
  parameter int TAG_W = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [1:0]       policy,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_viol,
  output logic             halted,
  output logic [CNT_W-1:0] cf_cnt,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int W  = 32 + TAG_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_e          state;
  pol_e            pol;
  logic            cf;
  logic            viol;
  logic            accept;
  logic            wr_en;
  logic [W-1:0]    wr_word;
  logic [W-1:0]    rd_word;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full_unused;  // same information as fifo_count==DEPTH

  assign pol      = pol_e'(policy);
  assign cf       = is_cf(in_instr);
  assign viol     = cf && (in_tag == '0);
  assign in_ready = !rst && (state == ST_RUN) && (fifo_count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (!viol || pol == POL_PASS || pol == POL_ZERO);
  assign halted   = (state == ST_HALT);

  // Word written into the FIFO for the current input.
  always_comb begin
    wr_word = {1'b0, in_tag, in_instr};
    if (viol) begin
      if (pol == POL_ZERO) wr_word = {1'b1, {TAG_W{1'b0}}, 32'h0};
      else                 wr_word = {1'b1, in_tag, in_instr};
    end
  end

  scf_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_word),
    .pop     (out_ready),
    .rd_data (rd_word),
    .full    (fifo_full_unused),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_viol  = rd_word[W-1];
  assign out_tag   = rd_word[W-2:32];
  assign out_instr = rd_word[31:0];

  // RUN/HALT sequencing; a HALT violation takes priority over a same-cycle clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (accept && viol && pol == POL_HALT) state <= ST_HALT;
        ST_HALT: if (clr) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef SCF_STREAM_STATS_EN
  logic [CNT_W-1:0] cf_q;
  logic [CNT_W-1:0] viol_q;

  // Saturating statistics over accepted words; clr leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_q   <= '0;
      viol_q <= '0;
    end else if (accept) begin
      if (cf && cf_q != '1)     cf_q   <= cf_q + 1'b1;
      if (viol && viol_q != '1) viol_q <= viol_q + 1'b1;
    end
  end

  assign cf_cnt   = cf_q;
  assign viol_cnt = viol_q;
`else
  assign cf_cnt   = '0;
  assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_scf_stream.sv
// Directed bench for scf_stream (DEPTH=4, TAG_W=32, CNT_W=16).
module tb_scf_stream;

`ifdef SCF_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic [1:0]  policy;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_tag;
  logic        out_viol;
  logic        halted;
  logic [15:0] cf_cnt;
  logic [15:0] viol_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  scf_stream #(.TAG_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_tag    (in_tag),
    .policy    (policy),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_tag   (out_tag),
    .out_viol  (out_viol),
    .halted    (halted),
    .cf_cnt    (cf_cnt),
    .viol_cnt  (viol_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ecnt(input int v);
    return STATS ? 16'(v) : 16'd0;
  endfunction

  task automatic push(input logic [31:0] i, input logic [31:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = i;
    in_tag   = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] ei,
                         input logic [31:0] et, input logic ev);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_instr"}, 64'(out_instr), 64'(ei));
    chk({nm, "_tag"},   64'(out_tag),   64'(et));
    chk({nm, "_viol"},  64'(out_viol),  64'(ev));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    policy = 2'd1; clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_tag",  64'(out_tag),   64'd0);
    chk("rst_out_viol", 64'(out_viol),  64'd0);
    chk("rst_halted",   64'(halted),    64'd0);
    chk("rst_cf_cnt",   64'(cf_cnt),    64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("run_in_ready", 64'(in_ready), 64'd1);

    // Non-CF passthrough under ZERO, one-cycle latency.
    chk("nc_pre_valid", 64'(out_valid), 64'd0);
    push(32'h0000_0820, 32'h0);
    chk("nc_latency", 64'(out_valid), 64'd1);
    chk("nc_cf_cnt", 64'(cf_cnt), 64'(ecnt(0)));
    pop_chk("nc", 32'h0000_0820, 32'h0, 1'b0);

    // ZERO policy.
    push(32'h1000_0000, 32'h0);
    pop_chk("zero_v", 32'h0, 32'h0, 1'b1);
    push(32'h1000_0001, 32'h1);
    pop_chk("zero_ok", 32'h1000_0001, 32'h1, 1'b0);
    chk("zero_cf_cnt",   64'(cf_cnt),   64'(ecnt(2)));
    chk("zero_viol_cnt", 64'(viol_cnt), 64'(ecnt(1)));

    // DROP policy.
    policy = 2'd2;
    push(32'h0411_0000, 32'h0);
    chk("drop_none", 64'(out_valid), 64'd0);
    push(32'h2021_0001, 32'h0);
    pop_chk("drop", 32'h2021_0001, 32'h0, 1'b0);
    chk("drop_cf_cnt",   64'(cf_cnt),   64'(ecnt(3)));
    chk("drop_viol_cnt", 64'(viol_cnt), 64'(ecnt(2)));

    // HALT policy; buffered word still drains while halted.
    policy = 2'd3;
    push(32'h0000_0820, 32'h5);
    push(32'h0000_0008, 32'h0);
    chk("halt_halted",   64'(halted),   64'd1);
    chk("halt_in_ready", 64'(in_ready), 64'd0);
    chk("halt_viol_cnt", 64'(viol_cnt), 64'(ecnt(3)));
    pop_chk("halt_drain", 32'h0000_0820, 32'h5, 1'b0);
    chk("halt_jr_dropped", 64'(out_valid), 64'd0);
    push(32'h0000_0820, 32'h6);
    chk("halt_blocked", 64'(out_valid), 64'd0);
    pulse_clr();
    chk("clr_halted",   64'(halted),   64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    pulse_clr();
    chk("clr_run_ignored", 64'(halted), 64'd0);

    // clr coinciding with a HALT violation: halt wins.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_0008; in_tag = 32'h0; clr = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_vs_halt", 64'(halted), 64'd1);
    pulse_clr();
    chk("clr_vs_halt_exit", 64'(halted), 64'd0);

    // PASS policy.
    policy = 2'd0;
    push(32'h0800_0010, 32'h0);
    pop_chk("pass", 32'h0800_0010, 32'h0, 1'b1);
    chk("pass_cf_cnt",   64'(cf_cnt),   64'(ecnt(6)));
    chk("pass_viol_cnt", 64'(viol_cnt), 64'(ecnt(5)));

    // Backpressure: fill 4, fifth refused, drain in order across the wrap.
    for (int i = 1; i <= 4; i++) push({16'h0, 8'(i), 8'h20}, 32'(i));
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push({16'h0, 8'd5, 8'h20}, 32'd5);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("bp%0d", i), {16'h0, 8'(i), 8'h20}, 32'(i), 1'b0);
    chk("bp_fifth_refused", 64'(out_valid), 64'd0);
    push({16'h0, 8'd5, 8'h20}, 32'd5);
    pop_chk("bp5", {16'h0, 8'd5, 8'h20}, 32'd5, 1'b0);

    // Simultaneous push and pop.
    push(32'h0000_0820, 32'hA);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_0020; in_tag = 32'hB; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_valid", 64'(out_valid), 64'd1);
    chk("pp_head",  64'(out_instr), 64'h0000_0020);
    pop_chk("pp", 32'h0000_0020, 32'hB, 1'b0);

    // Reset mid-stream with 3 words buffered and the block halted.
    for (int i = 0; i < 3; i++) push(32'h0000_0820, 32'(i + 16));
    policy = 2'd3;
    push(32'h0000_0008, 32'h0);
    chk("pre_rst_halted", 64'(halted), 64'd1);
    chk("pre_rst_cf_cnt", 64'(cf_cnt), 64'(ecnt(7)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready",  64'(in_ready),  64'd0);
    chk("mrst_halted",    64'(halted),    64'd0);
    chk("mrst_cf_cnt",    64'(cf_cnt),    64'd0);
    chk("mrst_viol_cnt",  64'(viol_cnt),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready),  64'd1);
    chk("post_rst_valid",    64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
